// File: rtl/add_pkg.sv
// Shared definitions for the adder job path: controller state encoding and
// default widths/delays reused by the worker and the top level.
package add_pkg;

    localparam int unsigned ADD_W         = 3;
    localparam int unsigned ADD_SUM_DELAY = 2;
    localparam int unsigned ADD_TIMEOUT   = 2048;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        CAPTURE,
        RESP
    } add_state_t;

endpackage

// File: rtl/add_job_timer.sv
// Clear/enable up-counter that saturates at TERMINAL and flags when it is there.
module add_job_timer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != TC_VALUE)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TC_VALUE);

endmodule

// File: rtl/add_job_ctrl.sv
// Initiator for the enable/done adder worker: takes operand pairs on a
// valid/ready request, launches the worker, and returns the sum or a timeout.
module add_job_ctrl
    import add_pkg::*;
#(
    parameter int unsigned W         = ADD_W,
    parameter int unsigned SUM_DELAY = ADD_SUM_DELAY,
    parameter int unsigned TIMEOUT   = ADD_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_timeout,
    output logic         add_enable,
    output logic [W-1:0] add_num1,
    output logic [W-1:0] add_num2,
    input  logic         add_done,
    input  logic [W-1:0] add_sum,
    output logic         busy
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned DW = $clog2(SUM_DELAY) + 1;

    add_state_t state;
    add_state_t state_next;
    logic       timeout_tc;
    logic       delay_tc;

    // Timer is 0 in the first WAIT_DONE cycle, so tc marks the TIMEOUT-th one.
    add_job_timer #(.WIDTH(TW), .TERMINAL(TIMEOUT - 1)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == LAUNCH),
        .enable (state == WAIT_DONE),
        .tc     (timeout_tc)
    );

    // Cycle t+k after the done pulse sees count k-1; capture on the SUM_DELAY-th.
    add_job_timer #(.WIDTH(DW), .TERMINAL(SUM_DELAY - 1)) u_delay (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == WAIT_DONE) && add_done),
        .enable (state == CAPTURE),
        .tc     (delay_tc)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_valid) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (add_done)        state_next = CAPTURE;
                else if (timeout_tc) state_next = RESP;
            end
            CAPTURE:   if (delay_tc) state_next = RESP;
            RESP:      if (rsp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            add_num1    <= '0;
            add_num2    <= '0;
            rsp_sum     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        add_num1 <= req_a;
                        add_num2 <= req_b;
                    end
                end
                WAIT_DONE: begin
                    if (!add_done && timeout_tc) begin
                        rsp_sum     <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (delay_tc) begin
                        rsp_sum     <= add_sum;
                        rsp_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign add_enable = (state == LAUNCH);
    assign rsp_valid  = (state == RESP);

endmodule

// File: tb/tb_add_job_ctrl.sv
// Directed bench for add_job_ctrl: one instance with the default timeout and
// one with TIMEOUT=16, sharing inputs; outputs are observed through a selector.
module tb_add_job_ctrl;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b0;
    logic         add_done = 1'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [W-1:0] add_sum = '0;
    logic         sel = 1'b0;

    logic         a_req_ready, a_rsp_valid, a_rsp_timeout, a_add_enable, a_busy;
    logic [W-1:0] a_rsp_sum, a_num1, a_num2;
    logic         b_req_ready, b_rsp_valid, b_rsp_timeout, b_add_enable, b_busy;
    logic [W-1:0] b_rsp_sum, b_num1, b_num2;

    logic         m_req_ready, m_rsp_valid, m_rsp_timeout, m_add_enable, m_busy;
    logic [W-1:0] m_rsp_sum, m_num1, m_num2;

    always #5 clk = ~clk;

    add_job_ctrl #(.W(W), .SUM_DELAY(2), .TIMEOUT(2048)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(a_rsp_sum),
        .rsp_timeout(a_rsp_timeout), .add_enable(a_add_enable),
        .add_num1(a_num1), .add_num2(a_num2), .add_done(add_done), .add_sum(add_sum),
        .busy(a_busy)
    );

    add_job_ctrl #(.W(W), .SUM_DELAY(2), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(b_rsp_sum),
        .rsp_timeout(b_rsp_timeout), .add_enable(b_add_enable),
        .add_num1(b_num1), .add_num2(b_num2), .add_done(add_done), .add_sum(add_sum),
        .busy(b_busy)
    );

    assign m_req_ready   = sel ? b_req_ready   : a_req_ready;
    assign m_rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
    assign m_rsp_timeout = sel ? b_rsp_timeout : a_rsp_timeout;
    assign m_add_enable  = sel ? b_add_enable  : a_add_enable;
    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_rsp_sum     = sel ? b_rsp_sum     : a_rsp_sum;
    assign m_num1        = sel ? b_num1        : a_num1;
    assign m_num2        = sel ? b_num2        : a_num2;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Running protocol observations on the selected instance.
    int           en_cnt = 0;
    int           en_dbl = 0;
    int           stab_err = 0;
    int           rr_err = 0;
    logic         prev_en = 1'b0;
    logic         prev_busy = 1'b0;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] p2 = '0;

    always @(posedge clk) begin
        if (m_add_enable) en_cnt <= en_cnt + 1;
        if (m_add_enable && prev_en) en_dbl <= en_dbl + 1;
        if (m_busy && prev_busy && (m_num1 !== p1 || m_num2 !== p2)) stab_err <= stab_err + 1;
        if (m_busy && m_req_ready) rr_err <= rr_err + 1;
        prev_en   <= m_add_enable;
        prev_busy <= m_busy;
        p1        <= m_num1;
        p2        <= m_num2;
    end

    // dly < 0: worker never answers. lat is cycles from LAUNCH to first rsp_valid.
    task automatic job(input logic [W-1:0] a, input logic [W-1:0] b, input int dly,
                       input logic [W-1:0] wsum, input int hold, input logic tie,
                       input string tag, output logic [W-1:0] sum, output logic tmo,
                       output int lat, output int unst);
        int           k;
        int           base;
        logic [W-1:0] s0;
        logic         t0;
        lat  = -1;
        unst = 0;
        rsp_ready = tie;
        k = 0;
        while (!m_req_ready && k < 50) begin
            step;
            k++;
        end
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        step;
        req_valid = 1'b0;
        req_a = ~a;
        req_b = ~b;
        check({tag, "_enable"}, 32'(m_add_enable), 32'd1);
        check({tag, "_num"}, {26'd0, m_num1, m_num2}, {26'd0, a, b});
        base = (dly < 0) ? 0 : dly;
        for (int i = 0; i < base; i++) step;
        if (dly >= 0) add_done = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step;
            add_done = 1'b0;
            add_sum = (j == 2) ? wsum : ~wsum;
            if (m_rsp_valid) begin
                lat = base + j;
                break;
            end
        end
        check({tag, "_rsp_seen"}, 32'(m_rsp_valid), 32'd1);
        s0 = m_rsp_sum;
        t0 = m_rsp_timeout;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            step;
            if (m_rsp_valid !== 1'b1 || m_rsp_sum !== s0 || m_rsp_timeout !== t0 ||
                m_req_ready !== 1'b0) unst++;
        end
        rsp_ready = 1'b1;
        sum = m_rsp_sum;
        tmo = m_rsp_timeout;
        step;
        rsp_ready = tie;
        check({tag, "_valid_drop"}, 32'(m_rsp_valid), 32'd0);
        check({tag, "_back_idle"}, 32'(m_req_ready), 32'd1);
    endtask

    logic [W-1:0] s;
    logic         t;
    int           lat, unst, e0, vseen;

    initial begin
        // Reset state
        step;
        step;
        check("rst_req_ready", 32'(m_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_enable", 32'(m_add_enable), 32'd0);
        check("rst_outs", {24'd0, m_rsp_sum, m_num1, m_num2}, 32'd0);
        check("rst_timeout", 32'(m_rsp_timeout), 32'd0);
        reset = 1'b0;
        step;

        // 1: long worker latency, single enable, capture timing
        e0 = en_cnt;
        job(3'd3, 3'd2, 1025, 3'd5, 0, 1'b0, "t1", s, t, lat, unst);
        check("t1_sum", 32'(s), 32'd5);
        check("t1_timeout", 32'(t), 32'd0);
        check("t1_done_to_valid", 32'(lat - 1025), 32'd3);
        check("t1_enables", 32'(en_cnt - e0), 32'd1);

        // 2: wrap result and response backpressure
        job(3'd7, 3'd7, 4, 3'd6, 10, 1'b0, "t2", s, t, lat, unst);
        check("t2_sum", 32'(s), 32'd6);
        check("t2_timeout", 32'(t), 32'd0);
        check("t2_hold_stable", 32'(unst), 32'd0);

        // 6: back-to-back requests with rsp_ready tied high
        e0 = en_cnt;
        job(3'd1, 3'd2, 1, 3'd3, 0, 1'b1, "t6a", s, t, lat, unst);
        check("t6a_sum", 32'(s), 32'd3);
        job(3'd5, 3'd6, 2, 3'd3, 0, 1'b1, "t6b", s, t, lat, unst);
        check("t6b_sum", 32'(s), 32'd3);
        job(3'd4, 3'd4, 3, 3'd0, 0, 1'b1, "t6c", s, t, lat, unst);
        check("t6c_sum", 32'(s), 32'd0);
        job(3'd2, 3'd3, 5, 3'd5, 0, 1'b1, "t6d", s, t, lat, unst);
        check("t6d_sum", 32'(s), 32'd5);
        check("t6_enables", 32'(en_cnt - e0), 32'd4);
        rsp_ready = 1'b0;

        // 5: reset during WAIT_DONE aborts the job
        req_valid = 1'b1;
        req_a = 3'd1;
        req_b = 3'd1;
        step;
        req_valid = 1'b0;
        step;
        step;
        reset = 1'b1;
        step;
        check("t5_req_ready", 32'(m_req_ready), 32'd1);
        check("t5_busy", 32'(m_busy), 32'd0);
        check("t5_rsp_valid", 32'(m_rsp_valid), 32'd0);
        reset = 1'b0;
        add_done = 1'b1;
        add_sum = 3'd2;
        step;
        add_done = 1'b0;
        vseen = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (m_rsp_valid) vseen++;
        end
        check("t5_no_response", 32'(vseen), 32'd0);

        // Switch observation to the TIMEOUT=16 instance with both freshly reset
        sel = 1'b1;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
        step;

        // 3: worker never finishes
        job(3'd1, 3'd1, -1, 3'd2, 0, 1'b0, "t3", s, t, lat, unst);
        check("t3_latency", 32'(lat), 32'd17);
        check("t3_timeout", 32'(t), 32'd1);
        check("t3_sum", 32'(s), 32'd0);
        add_done = 1'b1;
        step;
        add_done = 1'b0;
        check("t3_stray_busy", 32'(m_busy), 32'd0);
        step;
        check("t3_stray_valid", 32'(m_rsp_valid), 32'd0);
        check("t3_stray_ready", 32'(m_req_ready), 32'd1);

        // 4: done coincides with the last timeout cycle
        job(3'd3, 3'd4, 16, 3'd7, 0, 1'b0, "t4", s, t, lat, unst);
        check("t4_timeout", 32'(t), 32'd0);
        check("t4_sum", 32'(s), 32'd7);
        check("t4_latency", 32'(lat), 32'd19);

        step;
        check("enable_never_double", 32'(en_dbl), 32'd0);
        check("operands_stable_busy", 32'(stab_err), 32'd0);
        check("req_ready_low_busy", 32'(rr_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
